video_timing_gen: RTL and testbench

- Parametrised raster timing generator. Replaces the fixed discrete-counter horizontal/vertical chain (clock-divider flops, 4-bit counter pairs, sync flops, vblank IRQ flop).
- Produces the pixel clock enable, H/V counters, sync, blank, a tile-load strobe and a latched CPU interrupt with acknowledge.
- Feeds the tile/bullet renderers, VGA output and the 6502 IRQ input.
- Geometry, divider, sync polarity and IRQ line are parameters, so arcade 256x224 and VGA-style modes share one block.

---
 rtl/video_timing_gen.sv | 146 ++++++++++++++
 tb/tb_video_timing_gen.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised raster timing generator.
// A clock divider produces the pixel enable; the H/V counters, sync, blank,
// display-enable and strobe outputs are all registered from next-state
// counter values so they move together with no skew. A latched active-low
// interrupt is raised at the start of a chosen line and cleared by irq_ack.

module video_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 256,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 32,
  parameter int H_BP     = 80,
  parameter int V_ACTIVE = 224,
  parameter int V_FP     = 16,
  parameter int V_SYNC   = 8,
  parameter int V_BP     = 16,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int IRQ_LINE = 224,
  parameter int HW       = 9,
  parameter int VW       = 9
) (
  input  logic          clk,
  input  logic          rst,
  output logic          pix_ce,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          hblank,
  output logic          vblank,
  output logic          de,
  output logic          tile_load,
  output logic          line_start,
  output logic          frame_start,
  output logic          irq_n,
  input  logic          irq_ack
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] IRQ_V    = VW'(IRQ_LINE);
  localparam logic          HS_ON    = (HS_POL != 0);
  localparam logic          VS_ON    = (VS_POL != 0);

  // Parameter sanity checks, reported while elaborating
  if (CLK_DIV < 1) begin : g_err_div
    $error("video_timing_gen: CLK_DIV must be at least 1");
  end
  if (HW < 3) begin : g_err_hw
    $error("video_timing_gen: HW must be at least 3 for the tile strobe");
  end
  if (H_TOTAL > (1 << HW)) begin : g_err_htot
    $error("video_timing_gen: H_TOTAL does not fit in HW bits");
  end
  if (V_TOTAL > (1 << VW)) begin : g_err_vtot
    $error("video_timing_gen: V_TOTAL does not fit in VW bits");
  end
  if (IRQ_LINE >= V_TOTAL) begin : g_err_irq
    $error("video_timing_gen: IRQ_LINE must be below V_TOTAL");
  end
  if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_err_porch
    $error("video_timing_gen: porch and sync widths must be non-zero");
  end

  logic [DW-1:0] div;
  logic [DW-1:0] div_next;
  logic          ce_next;
  logic          h_wrap;
  logic          v_wrap;
  logic [HW-1:0] h_next;
  logic [VW-1:0] v_next;
  logic          irq_set;

  // Next-state of divider and raster counters; counters only move on pixel enables
  always_comb begin
    div_next = (div == DIV_LAST) ? '0 : div + 1'b1;
    ce_next  = (div_next == DIV_LAST);
    h_wrap   = ce_next && (hcount == H_LAST);
    v_wrap   = h_wrap && (vcount == V_LAST);
    h_next   = hcount;
    v_next   = vcount;
    if (ce_next) begin
      h_next = h_wrap ? '0 : hcount + 1'b1;
    end
    if (h_wrap) begin
      v_next = v_wrap ? '0 : vcount + 1'b1;
    end
    irq_set  = h_wrap && (v_next == IRQ_V);
  end

  // Registered counters, decodes and strobes, all derived from next-state values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div         <= '0;
      pix_ce      <= 1'b0;
      hcount      <= '0;
      vcount      <= '0;
      hblank      <= 1'b0;
      vblank      <= 1'b0;
      de          <= 1'b1;
      hsync       <= ~HS_ON;
      vsync       <= ~VS_ON;
      tile_load   <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div         <= div_next;
      pix_ce      <= ce_next;
      hcount      <= h_next;
      vcount      <= v_next;
      hblank      <= (h_next >= H_ACT);
      vblank      <= (v_next >= V_ACT);
      de          <= (h_next < H_ACT) && (v_next < V_ACT);
      hsync       <= ((h_next >= HS_BEG) && (h_next < HS_END)) ? HS_ON : ~HS_ON;
      vsync       <= ((v_next >= VS_BEG) && (v_next < VS_END)) ? VS_ON : ~VS_ON;
      tile_load   <= ce_next && (hcount[2:0] == 3'b111);
      line_start  <= h_wrap;
      frame_start <= v_wrap;
    end
  end

  // Interrupt latch: raised entering the IRQ line, a same-cycle ack loses to the set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_n <= 1'b1;
    end else if (irq_set) begin
      irq_n <= 1'b0;
    end else if (irq_ack) begin
      irq_n <= 1'b1;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: directed bench for video_timing_gen.
// Four instances share clock, reset and irq_ack: the default arcade mode,
// a small CLK_DIV=2 raster for whole-frame and IRQ scenarios, a tiny
// CLK_DIV=1 positive-polarity raster, and a 640x480 positive-polarity mode.

module tb_video_timing_gen;

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic irq_ack = 1'b0;
  int   tests   = 0;
  int   fails   = 0;

  always #5 clk = ~clk;

  logic       d_pix_ce, d_hsync, d_vsync, d_hblank, d_vblank, d_de;
  logic       d_tile_load, d_line_start, d_frame_start, d_irq_n;
  logic [8:0] d_hcount, d_vcount;
  logic       s_pix_ce, s_hsync, s_vsync, s_hblank, s_vblank, s_de;
  logic       s_tile_load, s_line_start, s_frame_start, s_irq_n;
  logic [8:0] s_hcount, s_vcount;
  logic       t_pix_ce, t_hsync, t_vsync, t_hblank, t_vblank, t_de;
  logic       t_tile_load, t_line_start, t_frame_start, t_irq_n;
  logic [8:0] t_hcount, t_vcount;
  logic       v_pix_ce, v_hsync, v_vsync, v_hblank, v_vblank, v_de;
  logic       v_tile_load, v_line_start, v_frame_start, v_irq_n;
  logic [9:0] v_hcount, v_vcount;

  video_timing_gen u_def (
    .clk(clk), .rst(rst), .pix_ce(d_pix_ce), .hcount(d_hcount), .vcount(d_vcount),
    .hsync(d_hsync), .vsync(d_vsync), .hblank(d_hblank), .vblank(d_vblank), .de(d_de),
    .tile_load(d_tile_load), .line_start(d_line_start), .frame_start(d_frame_start),
    .irq_n(d_irq_n), .irq_ack(irq_ack)
  );

  video_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(16), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1), .IRQ_LINE(8)
  ) u_sml (
    .clk(clk), .rst(rst), .pix_ce(s_pix_ce), .hcount(s_hcount), .vcount(s_vcount),
    .hsync(s_hsync), .vsync(s_vsync), .hblank(s_hblank), .vblank(s_vblank), .de(s_de),
    .tile_load(s_tile_load), .line_start(s_line_start), .frame_start(s_frame_start),
    .irq_n(s_irq_n), .irq_ack(irq_ack)
  );

  video_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .HS_POL(1), .VS_POL(1), .IRQ_LINE(7)
  ) u_tny (
    .clk(clk), .rst(rst), .pix_ce(t_pix_ce), .hcount(t_hcount), .vcount(t_vcount),
    .hsync(t_hsync), .vsync(t_vsync), .hblank(t_hblank), .vblank(t_vblank), .de(t_de),
    .tile_load(t_tile_load), .line_start(t_line_start), .frame_start(t_frame_start),
    .irq_n(t_irq_n), .irq_ack(irq_ack)
  );

  video_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33), .HS_POL(1), .VS_POL(1),
    .IRQ_LINE(480), .HW(10), .VW(10)
  ) u_vga (
    .clk(clk), .rst(rst), .pix_ce(v_pix_ce), .hcount(v_hcount), .vcount(v_vcount),
    .hsync(v_hsync), .vsync(v_vsync), .hblank(v_hblank), .vblank(v_vblank), .de(v_de),
    .tile_load(v_tile_load), .line_start(v_line_start), .frame_start(v_frame_start),
    .irq_n(v_irq_n), .irq_ack(irq_ack)
  );

  // Advance one clock and land on the falling edge for sampling/driving
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [27:0] got9;
    logic [29:0] got10;
    rst = 1'b1;
    irq_ack = 1'b0;
    repeat (5) tick();
    got9 = {d_pix_ce, d_hcount, d_vcount, d_hsync, d_vsync, d_hblank, d_vblank, d_de,
            d_tile_load, d_line_start, d_frame_start, d_irq_n};
    tests++;
    if (got9 !== {1'b0, 9'd0, 9'd0, 2'b11, 3'b001, 3'b000, 1'b1}) begin
      fails++; $display("[TB] FAIL reset_def got %h want %h", got9, {1'b0, 9'd0, 9'd0, 2'b11, 3'b001, 3'b000, 1'b1});
    end
    got9 = {s_pix_ce, s_hcount, s_vcount, s_hsync, s_vsync, s_hblank, s_vblank, s_de,
            s_tile_load, s_line_start, s_frame_start, s_irq_n};
    tests++;
    if (got9 !== {1'b0, 9'd0, 9'd0, 2'b11, 3'b001, 3'b000, 1'b1}) begin
      fails++; $display("[TB] FAIL reset_sml got %h want %h", got9, {1'b0, 9'd0, 9'd0, 2'b11, 3'b001, 3'b000, 1'b1});
    end
    got9 = {t_pix_ce, t_hcount, t_vcount, t_hsync, t_vsync, t_hblank, t_vblank, t_de,
            t_tile_load, t_line_start, t_frame_start, t_irq_n};
    tests++;
    if (got9 !== {1'b0, 9'd0, 9'd0, 2'b00, 3'b001, 3'b000, 1'b1}) begin
      fails++; $display("[TB] FAIL reset_tny got %h want %h", got9, {1'b0, 9'd0, 9'd0, 2'b00, 3'b001, 3'b000, 1'b1});
    end
    got10 = {v_pix_ce, v_hcount, v_vcount, v_hsync, v_vsync, v_hblank, v_vblank, v_de,
             v_tile_load, v_line_start, v_frame_start, v_irq_n};
    tests++;
    if (got10 !== {1'b0, 10'd0, 10'd0, 2'b00, 3'b001, 3'b000, 1'b1}) begin
      fails++; $display("[TB] FAIL reset_vga got %h want %h", got10, {1'b0, 10'd0, 10'd0, 2'b00, 3'b001, 3'b000, 1'b1});
    end
  endtask

  // The release cycle (divider 0) is clock 1, so the first pixel enable is clock 4
  task automatic test_first_pix_ce();
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      tests++;
      if (d_pix_ce !== ((k == 3) ? 1'b1 : 1'b0)) begin
        fails++; $display("[TB] FAIL first_pix_ce clk %0d got %b want %b", k + 1, d_pix_ce, (k == 3));
      end
      tests++;
      if (d_hcount !== ((k >= 3) ? 9'd1 : 9'd0)) begin
        fails++; $display("[TB] FAIL first_hcount clk %0d got %0d want %0d", k + 1, d_hcount, (k >= 3) ? 1 : 0);
      end
      tests++;
      if (v_pix_ce !== 1'b1 || int'(v_hcount) != k) begin
        fails++; $display("[TB] FAIL div1_start clk %0d got ce=%b h=%0d want ce=1 h=%0d", k + 1, v_pix_ce, v_hcount, k);
      end
    end
  endtask

  task automatic test_line_default();
    int  h, pc, tl, hs_cnt, hmin, hmax, bad_hs, bad_hb, de_cnt, extra_ls;
    bit  found;
    found = 1'b0;
    for (int n = 0; n < 2000 && !found; n++) begin
      tick();
      found = (d_line_start === 1'b1);
    end
    tests++;
    if (!found) begin
      fails++; $display("[TB] FAIL def_line_wait got none want line_start within 2000 clks");
      return;
    end
    tests++;
    if (d_vcount !== 9'd1 || d_hcount !== 9'd0) begin
      fails++; $display("[TB] FAIL def_first_line got h=%0d v=%0d want h=0 v=1", d_hcount, d_vcount);
    end
    pc = 0; tl = 0; hs_cnt = 0; hmin = 9999; hmax = -1; bad_hs = 0; bad_hb = 0; de_cnt = 0; extra_ls = 0;
    for (int k = 0; k < 1536; k++) begin
      h = int'(d_hcount);
      if (k > 0 && d_line_start === 1'b1) extra_ls++;
      if (d_tile_load === 1'b1) tl++;
      if (d_pix_ce === 1'b1) begin
        pc++;
        if (d_de === 1'b1) de_cnt++;
        if (d_hsync === 1'b0) begin
          hs_cnt++;
          if (h < hmin) hmin = h;
          if (h > hmax) hmax = h;
        end
      end
      if (d_hsync !== ((h >= 272 && h < 304) ? 1'b0 : 1'b1)) bad_hs++;
      if (d_hblank !== ((h >= 256) ? 1'b1 : 1'b0)) bad_hb++;
      tick();
    end
    tests++;
    if (pc != 384) begin fails++; $display("[TB] FAIL def_pix_per_line got %0d want 384", pc); end
    tests++;
    if (tl != 48) begin fails++; $display("[TB] FAIL def_tile_loads got %0d want 48", tl); end
    tests++;
    if (hs_cnt != 32 || hmin != 272 || hmax != 303) begin
      fails++; $display("[TB] FAIL def_hsync_span got n=%0d %0d..%0d want n=32 272..303", hs_cnt, hmin, hmax);
    end
    tests++;
    if (bad_hs != 0 || bad_hb != 0) begin
      fails++; $display("[TB] FAIL def_h_decode got hs_err=%0d hb_err=%0d want 0 0", bad_hs, bad_hb);
    end
    tests++;
    if (de_cnt != 256) begin fails++; $display("[TB] FAIL def_de_per_line got %0d want 256", de_cnt); end
    tests++;
    if (extra_ls != 0 || d_line_start !== 1'b1 || d_hcount !== 9'd0 || d_vcount !== 9'd2) begin
      fails++; $display("[TB] FAIL def_line_period got extra=%0d ls=%b h=%0d v=%0d want 0 1 0 2",
                        extra_ls, d_line_start, d_hcount, d_vcount);
    end
  endtask

  task automatic test_line_vga();
    int  h, pc, hs_cnt, hmin, hmax, bad_hb, vs_cnt;
    bit  found;
    found = 1'b0;
    for (int n = 0; n < 1000 && !found; n++) begin
      tick();
      found = (v_line_start === 1'b1);
    end
    tests++;
    if (!found) begin
      fails++; $display("[TB] FAIL vga_line_wait got none want line_start within 1000 clks");
      return;
    end
    pc = 0; hs_cnt = 0; hmin = 9999; hmax = -1; bad_hb = 0; vs_cnt = 0;
    for (int k = 0; k < 800; k++) begin
      h = int'(v_hcount);
      if (v_pix_ce === 1'b1) pc++;
      if (v_vsync === 1'b1) vs_cnt++;
      if (v_hsync === 1'b1) begin
        hs_cnt++;
        if (h < hmin) hmin = h;
        if (h > hmax) hmax = h;
      end
      if (v_hblank !== ((h >= 640) ? 1'b1 : 1'b0)) bad_hb++;
      tick();
    end
    tests++;
    if (pc != 800) begin fails++; $display("[TB] FAIL vga_pix_ce got %0d want 800", pc); end
    tests++;
    if (hs_cnt != 96 || hmin != 656 || hmax != 751) begin
      fails++; $display("[TB] FAIL vga_hsync_span got n=%0d %0d..%0d want n=96 656..751", hs_cnt, hmin, hmax);
    end
    tests++;
    if (bad_hb != 0 || vs_cnt != 0) begin
      fails++; $display("[TB] FAIL vga_blank_vsync got hb_err=%0d vs_high=%0d want 0 0", bad_hb, vs_cnt);
    end
    tests++;
    if (v_line_start !== 1'b1 || v_hcount !== 10'd0) begin
      fails++; $display("[TB] FAIL vga_line_period got ls=%b h=%0d want 1 0", v_line_start, v_hcount);
    end
  endtask

  // 20x12 raster at CLK_DIV=2: hsync low 17..18, vsync low lines 9..10
  task automatic test_frame_small();
    int  h, v, pc, de_cnt, tl, tl_wrap, ls, extra_fs, bad_fs_ls, bad_dec, vmin, vmax;
    bit  found;
    found = 1'b0;
    for (int n = 0; n < 1000 && !found; n++) begin
      tick();
      found = (s_frame_start === 1'b1);
    end
    tests++;
    if (!found) begin
      fails++; $display("[TB] FAIL sml_frame_wait got none want frame_start within 1000 clks");
      return;
    end
    pc = 0; de_cnt = 0; tl = 0; tl_wrap = 0; ls = 0; extra_fs = 0; bad_fs_ls = 0; bad_dec = 0;
    vmin = 9999; vmax = -1;
    for (int k = 0; k < 480; k++) begin
      h = int'(s_hcount);
      v = int'(s_vcount);
      if (s_pix_ce === 1'b1) begin
        pc++;
        if (s_de === 1'b1) de_cnt++;
        if (s_vsync === 1'b0) begin
          if (v < vmin) vmin = v;
          if (v > vmax) vmax = v;
        end
      end
      if (s_tile_load === 1'b1) begin
        tl++;
        if (h == 0) tl_wrap++;
      end
      if (s_line_start === 1'b1) ls++;
      if (k > 0 && s_frame_start === 1'b1) extra_fs++;
      if (s_frame_start === 1'b1 && s_line_start !== 1'b1) bad_fs_ls++;
      if (s_hsync !== ((h >= 17 && h < 19) ? 1'b0 : 1'b1)) bad_dec++;
      if (s_vsync !== ((v >= 9 && v < 11) ? 1'b0 : 1'b1)) bad_dec++;
      if (s_vblank !== ((v >= 8) ? 1'b1 : 1'b0)) bad_dec++;
      if (s_de !== ((h < 16 && v < 8) ? 1'b1 : 1'b0)) bad_dec++;
      tick();
    end
    tests++;
    if (pc != 240 || de_cnt != 128) begin
      fails++; $display("[TB] FAIL sml_counts got pix=%0d de=%0d want 240 128", pc, de_cnt);
    end
    tests++;
    if (tl != 24 || tl_wrap != 0) begin
      fails++; $display("[TB] FAIL sml_tile_load got n=%0d at_wrap=%0d want 24 0", tl, tl_wrap);
    end
    tests++;
    if (ls != 12 || bad_fs_ls != 0) begin
      fails++; $display("[TB] FAIL sml_line_start got n=%0d fs_without_ls=%0d want 12 0", ls, bad_fs_ls);
    end
    tests++;
    if (bad_dec != 0 || vmin != 9 || vmax != 10) begin
      fails++; $display("[TB] FAIL sml_decode got err=%0d vs_lines %0d..%0d want 0 9..10", bad_dec, vmin, vmax);
    end
    tests++;
    if (extra_fs != 0 || s_frame_start !== 1'b1 || s_hcount !== 9'd0 || s_vcount !== 9'd0) begin
      fails++; $display("[TB] FAIL sml_frame_period got extra=%0d fs=%b h=%0d v=%0d want 0 1 0 0",
                        extra_fs, s_frame_start, s_hcount, s_vcount);
    end
  endtask

  // 16x8 raster at CLK_DIV=1, positive sync; H_TOTAL-1 ends in 7 so the wrap loads a tile
  task automatic test_frame_tiny();
    int  h, v, pc, tl, tl_wrap, bad_dec;
    bit  found;
    found = 1'b0;
    for (int n = 0; n < 400 && !found; n++) begin
      tick();
      found = (t_frame_start === 1'b1);
    end
    tests++;
    if (!found) begin
      fails++; $display("[TB] FAIL tny_frame_wait got none want frame_start within 400 clks");
      return;
    end
    pc = 0; tl = 0; tl_wrap = 0; bad_dec = 0;
    for (int k = 0; k < 128; k++) begin
      h = int'(t_hcount);
      v = int'(t_vcount);
      if (t_pix_ce === 1'b1) pc++;
      if (t_tile_load === 1'b1) begin
        tl++;
        if (h == 0) tl_wrap++;
      end
      if (t_hsync !== ((h >= 10 && h < 13) ? 1'b1 : 1'b0)) bad_dec++;
      if (t_vsync !== ((v >= 5 && v < 7) ? 1'b1 : 1'b0)) bad_dec++;
      if (t_hblank !== ((h >= 8) ? 1'b1 : 1'b0)) bad_dec++;
      tick();
    end
    tests++;
    if (pc != 128) begin fails++; $display("[TB] FAIL tny_pix_ce got %0d want 128", pc); end
    tests++;
    if (tl != 16 || tl_wrap != 8) begin
      fails++; $display("[TB] FAIL tny_tile_load got n=%0d at_wrap=%0d want 16 8", tl, tl_wrap);
    end
    tests++;
    if (bad_dec != 0) begin fails++; $display("[TB] FAIL tny_decode got err=%0d want 0", bad_dec); end
    tests++;
    if (t_frame_start !== 1'b1 || t_vcount !== 9'd0) begin
      fails++; $display("[TB] FAIL tny_frame_period got fs=%b v=%0d want 1 0", t_frame_start, t_vcount);
    end
  endtask

  task automatic test_irq();
    bit found;
    int early, sets;
    found = 1'b0;
    for (int n = 0; n < 1000 && !found; n++) begin
      tick();
      found = (s_frame_start === 1'b1);
    end
    tests++;
    if (!found) begin
      fails++; $display("[TB] FAIL irq_align got none want frame_start within 1000 clks");
      return;
    end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    tests++;
    if (s_irq_n !== 1'b1) begin fails++; $display("[TB] FAIL irq_clear_first got %b want 1", s_irq_n); end
    found = 1'b0; early = 0;
    for (int n = 0; n < 1000 && !found; n++) begin
      tick();
      if (s_pix_ce === 1'b1 && s_hcount === 9'd0 && s_vcount === 9'd8) found = 1'b1;
      else if (s_irq_n !== 1'b1) early++;
    end
    tests++;
    if (!found || early != 0) begin
      fails++; $display("[TB] FAIL irq_set_wait got found=%0d early=%0d want 1 0", found, early);
    end
    tests++;
    if (s_irq_n !== 1'b0) begin fails++; $display("[TB] FAIL irq_set got %b want 0", s_irq_n); end
    repeat (100) tick();
    tests++;
    if (s_irq_n !== 1'b0) begin fails++; $display("[TB] FAIL irq_latched got %b want 0", s_irq_n); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    tests++;
    if (s_irq_n !== 1'b1) begin fails++; $display("[TB] FAIL irq_ack_pulse got %b want 1", s_irq_n); end
    irq_ack = 1'b1;
    found = 1'b0; early = 0;
    for (int n = 0; n < 1000 && !found; n++) begin
      tick();
      if (s_pix_ce === 1'b1 && s_hcount === 9'd0 && s_vcount === 9'd8) found = 1'b1;
      else if (s_irq_n !== 1'b1) early++;
    end
    tests++;
    if (!found || early != 0 || s_irq_n !== 1'b0) begin
      fails++; $display("[TB] FAIL irq_set_vs_ack got found=%0d early=%0d irq_n=%b want 1 0 0", found, early, s_irq_n);
    end
    tick();
    tests++;
    if (s_irq_n !== 1'b1) begin fails++; $display("[TB] FAIL irq_held_ack_clear got %b want 1", s_irq_n); end
    irq_ack = 1'b0;
    sets = 0;
    for (int n = 0; n < 2000 && sets < 2; n++) begin
      tick();
      if (s_pix_ce === 1'b1 && s_hcount === 9'd0 && s_vcount === 9'd8) sets++;
    end
    tests++;
    if (sets != 2 || s_irq_n !== 1'b0) begin
      fails++; $display("[TB] FAIL irq_reset_twice got sets=%0d irq_n=%b want 2 0", sets, s_irq_n);
    end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    repeat (20) tick();
    tests++;
    if (s_irq_n !== 1'b1) begin fails++; $display("[TB] FAIL irq_no_queue got %b want 1", s_irq_n); end
  endtask

  task automatic test_async_reset();
    bit found;
    int n_fs, n_ls;
    found = 1'b0;
    for (int n = 0; n < 2000 && !found; n++) begin
      tick();
      found = (d_pix_ce === 1'b1 && d_hcount === 9'd150);
    end
    tests++;
    if (!found) begin
      fails++; $display("[TB] FAIL async_wait got none want hcount 150 within 2000 clks");
      return;
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({d_pix_ce, d_hcount, d_vcount} !== 19'd0) begin
      fails++; $display("[TB] FAIL async_def_counters got ce=%b h=%0d v=%0d want 0 0 0", d_pix_ce, d_hcount, d_vcount);
    end
    tests++;
    if ({d_hsync, d_vsync, d_hblank, d_vblank, d_de, d_tile_load, d_line_start, d_frame_start, d_irq_n} !== 9'b110010001) begin
      fails++; $display("[TB] FAIL async_def_outputs got %b want 110010001",
                        {d_hsync, d_vsync, d_hblank, d_vblank, d_de, d_tile_load, d_line_start, d_frame_start, d_irq_n});
    end
    tests++;
    if ({s_hcount, s_vcount} !== 18'd0) begin
      fails++; $display("[TB] FAIL async_sml_counters got h=%0d v=%0d want 0 0", s_hcount, s_vcount);
    end
    @(negedge clk);
    repeat (3) tick();
    rst = 1'b0;
    n_fs = -1; n_ls = -1;
    for (int n = 1; n <= 1600; n++) begin
      tick();
      if (n_fs < 0 && s_frame_start === 1'b1) n_fs = n;
      if (n_ls < 0 && d_line_start === 1'b1) n_ls = n;
    end
    tests++;
    if (n_fs != 479) begin fails++; $display("[TB] FAIL restart_sml_frame got edge %0d want 479", n_fs); end
    tests++;
    if (n_ls != 1535) begin fails++; $display("[TB] FAIL restart_def_line got edge %0d want 1535", n_ls); end
  endtask

  initial begin
    test_reset();
    test_first_pix_ce();
    test_line_default();
    test_line_vga();
    test_frame_small();
    test_frame_tiny();
    test_irq();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
